// File: rtl/param_memory_pkg.sv
// rtl/param_memory_pkg.sv - shared defaults and FSM encoding for param_memory
package param_memory_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int DEPTH_DEF  = 1024;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - RD_LAT-deep delay line for read data, completion and error
module mem_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] err;
    logic [DATA_W-1:0] dat [RD_LAT];

    // Data stages only load behind a valid, so the last stage holds between completions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            err <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            err[0] <= in_valid & in_err;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                err[i] <= err[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[RD_LAT-1];
    assign out_err   = err[RD_LAT-1];
    assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/param_memory.sv
// rtl/param_memory.sv - byte-enabled 1R1W word memory with zeroing init sweep
module param_memory
    import param_memory_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [ADDR_W-1:0]   read_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                wr_done,
    output logic                rd_done,
    output logic                busy,
    output logic                addr_err
);

    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   init_addr;
    logic                wr_acc;
    logic                rd_acc;
    logic                wr_ok;
    logic                rd_ok;
    logic [DATA_W-1:0]   wr_old;
    logic [DATA_W-1:0]   wr_merged;
    logic [DATA_W-1:0]   rd_word;
    logic                wr_err_q;
    logic                rd_err;

    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                init_addr <= (init_addr == LAST_ADDR) ? '0 : init_addr + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (init_addr == LAST_ADDR) state_nxt = RUN;
            RUN:  state_nxt = RUN;
        endcase
    end

    assign busy   = (state == INIT);
    assign wr_acc = write && (state == RUN);
    assign rd_acc = read && (state == RUN);
    assign wr_ok  = {1'b0, write_addr} < DEPTH_X;
    assign rd_ok  = {1'b0, read_addr} < DEPTH_X;

    assign wr_old = mem[write_addr];

    always_comb begin
        wr_merged = wr_old;
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Same-address read sees the merged word being written this edge.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = (wr_acc && wr_ok && (write_addr == read_addr)) ? wr_merged : mem[read_addr];
        end
    end

    // Storage has no reset; the INIT sweep is the only way it gets cleared.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_addr] <= '0;
        end else if (wr_acc && wr_ok) begin
            mem[write_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_done  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_done  <= wr_acc;
            wr_err_q <= wr_acc & ~wr_ok;
        end
    end

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .in_err    (~rd_ok),
        .out_valid (rd_done),
        .out_data  (rd_data),
        .out_err   (rd_err)
    );

    assign addr_err = wr_err_q | rd_err;

endmodule

// File: tb/tb_param_memory.sv
// tb/tb_param_memory.sv - directed self-checking bench for param_memory
module tb_param_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic        write;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [9:0]  write_addr;
    logic [9:0]  read_addr;

    logic [31:0] rd_data_a, rd_data_b;
    logic        wr_done_a, wr_done_b;
    logic        rd_done_a, rd_done_b;
    logic        busy_a, busy_b;
    logic        addr_err_a, addr_err_b;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // a: defaults (1024 words, RD_LAT=1); b: 1000 words, RD_LAT=2
    param_memory #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .read(read), .write(write), .wr_data(wr_data),
        .wr_be(wr_be), .write_addr(write_addr), .read_addr(read_addr),
        .rd_data(rd_data_a), .wr_done(wr_done_a), .rd_done(rd_done_a),
        .busy(busy_a), .addr_err(addr_err_a)
    );

    param_memory #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .read(read), .write(write), .wr_data(wr_data),
        .wr_be(wr_be), .write_addr(write_addr), .read_addr(read_addr),
        .rd_data(rd_data_b), .wr_done(wr_done_b), .rd_done(rd_done_b),
        .busy(busy_b), .addr_err(addr_err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_sweep(input string tag);
        int  ka = 0;
        int  kb = 0;
        bit  spurious = 1'b0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (!busy_a && ka == 0) ka = k;
            if (!busy_b && kb == 0) kb = k;
            if (k < 1000 && (wr_done_a || wr_done_b || rd_done_a || rd_done_b || addr_err_a || addr_err_b))
                spurious = 1'b1;
            if (k == 10) begin
                read  = 1'b0;
                write = 1'b0;
            end
        end
        chk({tag, "_busy_cycles_a"}, 32'(ka), 32'd1024);
        chk({tag, "_busy_cycles_b"}, 32'(kb), 32'd1000);
        chk({tag, "_no_pulses_in_init"}, {31'd0, spurious}, 32'd0);
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be,
                            input logic err_a, input logic err_b);
        write = 1'b1; write_addr = addr; wr_data = data; wr_be = be;
        tick();
        chk("wr_done_a", {31'd0, wr_done_a}, 32'd1);
        chk("wr_done_b", {31'd0, wr_done_b}, 32'd1);
        chk("wr_addr_err_a", {31'd0, addr_err_a}, {31'd0, err_a});
        chk("wr_addr_err_b", {31'd0, addr_err_b}, {31'd0, err_b});
        write = 1'b0;
        tick();
        chk("wr_done_a_one_cycle", {31'd0, wr_done_a}, 32'd0);
        chk("wr_done_b_one_cycle", {31'd0, wr_done_b}, 32'd0);
    endtask

    task automatic do_read(input logic [9:0] addr, input logic [31:0] ea, input logic [31:0] eb,
                           input logic err_a, input logic err_b);
        read = 1'b1; read_addr = addr;
        tick();
        chk("rd_done_a_lat1", {31'd0, rd_done_a}, 32'd1);
        chk("rd_data_a", rd_data_a, ea);
        chk("rd_addr_err_a", {31'd0, addr_err_a}, {31'd0, err_a});
        chk("rd_done_b_not_yet", {31'd0, rd_done_b}, 32'd0);
        read = 1'b0;
        tick();
        chk("rd_done_b_lat2", {31'd0, rd_done_b}, 32'd1);
        chk("rd_data_b", rd_data_b, eb);
        chk("rd_addr_err_b", {31'd0, addr_err_b}, {31'd0, err_b});
        chk("rd_done_a_one_cycle", {31'd0, rd_done_a}, 32'd0);
        chk("rd_data_a_held", rd_data_a, ea);
    endtask

    initial begin
        rst = 1'b1; read = 1'b0; write = 1'b0;
        wr_data = 32'h0; wr_be = 4'h0; write_addr = 10'd0; read_addr = 10'd0;
        #12;
        chk("reset_busy_a", {31'd0, busy_a}, 32'd1);
        chk("reset_busy_b", {31'd0, busy_b}, 32'd1);
        chk("reset_rd_data_a", rd_data_a, 32'h0);
        chk("reset_done_err", {28'd0, wr_done_a, rd_done_b, addr_err_a, addr_err_b}, 32'h0);

        // requests during the sweep must be ignored
        read = 1'b1; write = 1'b1; read_addr = 10'd5; write_addr = 10'd5;
        wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        rst = 1'b0;
        wait_sweep("init1");

        do_read(10'd5, 32'h0, 32'h0, 1'b0, 1'b0);

        do_write(10'd0, 32'h7ABC9C86, 4'hF, 1'b0, 1'b0);
        do_read(10'd0, 32'h7ABC9C86, 32'h7ABC9C86, 1'b0, 1'b0);

        do_write(10'd3, 32'h11223344, 4'hF, 1'b0, 1'b0);
        do_write(10'd3, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0);
        do_read(10'd3, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0);

        do_write(10'd3, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
        do_read(10'd3, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0);

        // same-cycle read/write collision, full then partial
        read = 1'b1; write = 1'b1; read_addr = 10'd7; write_addr = 10'd7;
        wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        tick();
        chk("coll_wr_done_a", {31'd0, wr_done_a}, 32'd1);
        chk("coll_rd_data_a", rd_data_a, 32'hDEADBEEF);
        wr_data = 32'h00000000; wr_be = 4'h3;
        tick();
        chk("coll_rd_data_b", rd_data_b, 32'hDEADBEEF);
        chk("coll_partial_a", rd_data_a, 32'hDEAD0000);
        read = 1'b0; write = 1'b0;
        tick();
        chk("coll_partial_b", rd_data_b, 32'hDEAD0000);

        // out of range: 1000 is valid for a, invalid for b
        do_write(10'd999, 32'h99999999, 4'hF, 1'b0, 1'b0);
        do_write(10'd1000, 32'h12345678, 4'hF, 1'b0, 1'b1);
        do_read(10'd1000, 32'h12345678, 32'h0, 1'b0, 1'b1);
        do_read(10'd999, 32'h99999999, 32'h99999999, 1'b0, 1'b0);

        // b: read error and write error land in the same output cycle
        read = 1'b1; read_addr = 10'd1000;
        tick();
        read = 1'b0; write = 1'b1; write_addr = 10'd1000; wr_data = 32'h55; wr_be = 4'hF;
        tick();
        chk("both_err_b", {29'd0, rd_done_b, wr_done_b, addr_err_b}, 32'h7);
        chk("both_err_rd_data_b", rd_data_b, 32'h0);
        chk("both_err_a_clean", {31'd0, addr_err_a}, 32'd0);
        write = 1'b0;
        tick();
        chk("both_err_b_single", {31'd0, addr_err_b}, 32'd0);

        // back-to-back pipelined reads
        read = 1'b1; read_addr = 10'd0;
        tick();
        chk("pipe_a0", rd_data_a, 32'h7ABC9C86);
        read_addr = 10'd3;
        tick();
        chk("pipe_a1", rd_data_a, 32'h11BB33DD);
        chk("pipe_b0", rd_data_b, 32'h7ABC9C86);
        read_addr = 10'd7;
        tick();
        chk("pipe_a2", rd_data_a, 32'hDEAD0000);
        chk("pipe_b1", rd_data_b, 32'h11BB33DD);
        read = 1'b0;
        tick();
        chk("pipe_b2", rd_data_b, 32'hDEAD0000);
        chk("pipe_b2_done", {30'd0, rd_done_a, rd_done_b}, 32'h1);

        // reset in the cycle after a read is accepted
        read = 1'b1; read_addr = 10'd0;
        tick();
        read = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_done", {30'd0, rd_done_a, rd_done_b}, 32'h0);
        chk("mid_rst_rd_data_a", rd_data_a, 32'h0);
        chk("mid_rst_rd_data_b", rd_data_b, 32'h0);
        chk("mid_rst_busy", {30'd0, busy_a, busy_b}, 32'h3);
        tick();
        tick();
        #1;
        rst = 1'b0;
        wait_sweep("init2");
        do_read(10'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
